multicycle_mips_control: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 57 +++++
 rtl/mips_ctrl_outdec.sv | 81 ++++++++
 rtl/multicycle_mips_control.sv | 144 ++++++++++++++
 tb/tb_multicycle_mips_control.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

  // Full set of datapath strobes and selects produced each cycle
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       halted;
  } ctrl_t;

  // States that sit waiting on the memory handshake
  function automatic logic is_mem_wait(state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore output decode; only the load enables that capture memory data
// look at mem_ready so nothing is latched before the access completes.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Per-state strobe and select decode, everything else defaults to 0
  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        // Precompute branch target into ALUOut
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEMRD: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.mdr_write = mem_ready;
      end
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_src        = PC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      JUMP: begin
        ctrl.pc_src   = PC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      TRAP: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_mips_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequencing,
// memory-wait timeout, trap capture and retired-instruction count.
module multicycle_mips_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state, state_nxt;
  logic [1:0]        cause_q, cause_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  retired_q;
  logic              timeout_hit;
  logic              retire;
  ctrl_t             ctrl;

  // The branch decision is made in the datapath (pc_write_cond & zero)
  logic unused_zero;
  assign unused_zero = zero;

  // A completing access on the final wait cycle beats the timeout
  assign timeout_hit = (TIMEOUT != 0) && !mem_ready && is_mem_wait(state) &&
                       (wait_cnt == WAIT_W'(TIMEOUT - 1));

  assign retire = (state_nxt == FETCH) &&
                  ((state == MEMWB)  || (state == MEMWR)  || (state == ALUWB) ||
                   (state == BRANCH) || (state == ADDIWB) || (state == JUMP));

  // State, trap cause and retired counter; reset overrides any transition
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      cause_q   <= TRAP_NONE;
      retired_q <= '0;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Memory wait counter: counts stalled cycles, clears on ready or state change
  always_ff @(posedge clk) begin
    if (reset)                   wait_cnt <= '0;
    else if (state_nxt != state) wait_cnt <= '0;
    else if (mem_ready)          wait_cnt <= '0;
    else if (is_mem_wait(state)) wait_cnt <= wait_cnt + WAIT_W'(1);
    else                         wait_cnt <= '0;
  end

  // Next-state and trap-cause selection
  always_comb begin
    state_nxt = state;
    cause_nxt = cause_q;
    if (timeout_hit) begin
      state_nxt = TRAP;
      cause_nxt = TRAP_TIMEOUT;
    end else begin
      unique case (state)
        FETCH:  if (mem_ready) state_nxt = DECODE;
        DECODE: begin
          unique case (opcode)
            OP_LW, OP_SW: state_nxt = MEMADR;
            OP_RTYPE:     state_nxt = EXEC;
            OP_BEQ:       state_nxt = BRANCH;
            OP_ADDI:      state_nxt = ADDIEX;
            OP_J:         state_nxt = JUMP;
            default: begin
              state_nxt = TRAP;
              cause_nxt = TRAP_ILLEGAL;
            end
          endcase
        end
        MEMADR: state_nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  if (mem_ready) state_nxt = MEMWB;
        MEMWB:  state_nxt = FETCH;
        MEMWR:  if (mem_ready) state_nxt = FETCH;
        EXEC:   state_nxt = ALUWB;
        ALUWB:  state_nxt = FETCH;
        BRANCH: state_nxt = FETCH;
        ADDIEX: state_nxt = ADDIWB;
        ADDIWB: state_nxt = FETCH;
        JUMP:   state_nxt = FETCH;
        TRAP:   state_nxt = TRAP;
        default: state_nxt = FETCH;
      endcase
    end
  end

  mips_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Strobes are suppressed while reset is high so an abandoned access never writes
  always_comb begin
    iord          = ctrl.iord;
    mem_read      = ctrl.mem_read      & ~reset;
    mem_write     = ctrl.mem_write     & ~reset;
    ir_write      = ctrl.ir_write      & ~reset;
    mdr_write     = ctrl.mdr_write     & ~reset;
    pc_write      = ctrl.pc_write      & ~reset;
    pc_write_cond = ctrl.pc_write_cond & ~reset;
    reg_write     = ctrl.reg_write     & ~reset;
    pc_src        = ctrl.pc_src;
    alu_src_a     = ctrl.alu_src_a;
    alu_src_b     = ctrl.alu_src_b;
    alu_op        = ctrl.alu_op;
    reg_dst       = ctrl.reg_dst;
    mem_to_reg    = ctrl.mem_to_reg;
    halted        = ctrl.halted;
  end

  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_mips_control.sv
// Directed bench for the multi-cycle MIPS control FSM with an output scoreboard.
module tb_multicycle_mips_control;

  typedef enum int {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
  } st_e;

  typedef struct {
    string       tag;
    logic [19:0] ctrl;
    logic [31:0] ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        iord, mem_read, mem_write, ir_write, mdr_write, pc_write, pc_write_cond;
  logic [1:0]  pc_src, alu_src_b, alu_op, trap_cause;
  logic        alu_src_a, reg_dst, mem_to_reg, reg_write, halted;
  logic [31:0] retired;
  logic [19:0] obs;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          stepno = 0;
  logic [31:0] exp_ret = 0;
  logic [1:0]  exp_cause = 0;

  always #5 clk = ~clk;

  multicycle_mips_control #(.CNT_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mdr_write(mdr_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .halted(halted), .trap_cause(trap_cause), .retired(retired)
  );

  assign obs = {iord, mem_read, mem_write, ir_write, mdr_write, pc_write, pc_write_cond,
                pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
                halted, trap_cause};

  // Reference control vector for a state, straight from the state table
  function automatic logic [19:0] exp_ctrl(st_e s, logic mr, logic rst, logic [1:0] cause);
    logic iord_e, mrd, mwr, irw, mdrw, pcw, pcwc, asa, rdst, m2r, rw, hlt;
    logic [1:0] pcs, asb, aop;
    {iord_e, mrd, mwr, irw, mdrw, pcw, pcwc, asa, rdst, m2r, rw, hlt} = '0;
    pcs = 2'd0; asb = 2'd0; aop = 2'd0;
    case (s)
      S_FETCH:  begin mrd = 1; asb = 2'd1; irw = mr; pcw = mr; end
      S_DECODE: asb = 2'd3;
      S_MEMADR: begin asa = 1; asb = 2'd2; end
      S_MEMRD:  begin iord_e = 1; mrd = 1; mdrw = mr; end
      S_MEMWB:  begin m2r = 1; rw = 1; end
      S_MEMWR:  begin iord_e = 1; mwr = 1; end
      S_EXEC:   begin asa = 1; aop = 2'd2; end
      S_ALUWB:  begin rdst = 1; rw = 1; end
      S_BRANCH: begin asa = 1; aop = 2'd1; pcs = 2'd1; pcwc = 1; end
      S_ADDIEX: begin asa = 1; asb = 2'd2; end
      S_ADDIWB: rw = 1;
      S_JUMP:   begin pcs = 2'd2; pcw = 1; end
      S_TRAP:   hlt = 1;
      default:  ;
    endcase
    if (rst) {mrd, mwr, irw, mdrw, pcw, pcwc, rw} = '0;
    return {iord_e, mrd, mwr, irw, mdrw, pcw, pcwc, pcs, asa, asb, aop,
            rdst, m2r, rw, hlt, cause};
  endfunction

  // One cycle: drive inputs, queue expectation, compare at negedge, advance
  task automatic step(input st_e s, input logic mr, input logic rst);
    exp_t e, got;
    mem_ready = mr;
    reset     = rst;
    e.tag  = $sformatf("%s#%0d", s.name(), stepno);
    e.ctrl = exp_ctrl(s, mr, rst, exp_cause);
    e.ret  = exp_ret;
    sbq.push_back(e);
    @(negedge clk);
    got = sbq.pop_front();
    checks++;
    assert (obs === got.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl observed=%h expected=%h", got.tag, obs, got.ctrl);
    end
    checks++;
    assert (retired === got.ret) else begin
      errors++;
      $error("FAIL %s retired observed=%0d expected=%0d", got.tag, retired, got.ret);
    end
    stepno++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; zero = 1'b0;
    @(posedge clk);
    #1;
    // reset held two cycles, then add
    step(S_FETCH, 1, 1);
    step(S_FETCH, 1, 1);
    step(S_FETCH, 1, 0);
    step(S_DECODE, 1, 0);
    step(S_EXEC, 1, 0);
    step(S_ALUWB, 1, 0);
    exp_ret = 1;
    // lw with three wait cycles in MEMRD
    opcode = 6'b100011;
    step(S_FETCH, 1, 0);
    step(S_DECODE, 1, 0);
    step(S_MEMADR, 1, 0);
    for (int i = 0; i < 3; i++) step(S_MEMRD, 0, 0);
    step(S_MEMRD, 1, 0);
    step(S_MEMWB, 1, 0);
    exp_ret = 2;
    // beq
    opcode = 6'b000100; zero = 1'b1;
    step(S_FETCH, 1, 0);
    step(S_DECODE, 1, 0);
    step(S_BRANCH, 1, 0);
    exp_ret = 3; zero = 1'b0;
    // sw
    opcode = 6'b101011;
    step(S_FETCH, 1, 0);
    step(S_DECODE, 1, 0);
    step(S_MEMADR, 1, 0);
    step(S_MEMWR, 1, 0);
    exp_ret = 4;
    // addi
    opcode = 6'b001000;
    step(S_FETCH, 1, 0);
    step(S_DECODE, 1, 0);
    step(S_ADDIEX, 1, 0);
    step(S_ADDIWB, 1, 0);
    exp_ret = 5;
    // j
    opcode = 6'b000010;
    step(S_FETCH, 1, 0);
    step(S_DECODE, 1, 0);
    step(S_JUMP, 1, 0);
    exp_ret = 6;
    // illegal opcode
    opcode = 6'b111111;
    step(S_FETCH, 1, 0);
    step(S_DECODE, 1, 0);
    exp_cause = 2'd1;
    for (int i = 0; i < 20; i++) step(S_TRAP, 1'($urandom_range(0, 1)), 0);
    step(S_TRAP, 0, 1);
    exp_cause = 2'd0; exp_ret = 0;
    // fetch timeout: 16 stalled cycles then TRAP
    step(S_FETCH, 0, 1);
    for (int i = 0; i < 16; i++) step(S_FETCH, 0, 0);
    exp_cause = 2'd2;
    step(S_TRAP, 0, 0);
    step(S_TRAP, 1, 0);
    step(S_TRAP, 0, 1);
    exp_cause = 2'd0;
    // ready arrives on the 16th stalled cycle: no trap
    opcode = 6'b001000;
    for (int i = 0; i < 15; i++) step(S_FETCH, 0, 0);
    step(S_FETCH, 1, 0);
    step(S_DECODE, 1, 0);
    step(S_ADDIEX, 1, 0);
    step(S_ADDIWB, 1, 0);
    exp_ret = 1;
    // reset during a pending store
    opcode = 6'b101011;
    step(S_FETCH, 1, 0);
    step(S_DECODE, 1, 0);
    step(S_MEMADR, 1, 0);
    step(S_MEMWR, 0, 0);
    step(S_MEMWR, 0, 1);
    exp_ret = 0;
    step(S_FETCH, 1, 0);
    step(S_DECODE, 1, 0);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover=%0d expected=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
